// File: rtl/qlf_k6n10_arith_pkg.sv
// Shared types and segment-geometry helpers for the
// k6n10 carry-chain arithmetic blocks.
package qlf_k6n10_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seg_state_t;

    function automatic int calc_nseg(input int w, input int s);
        return (w + s - 1) / s;
    endfunction

    function automatic int calc_lastw(input int w, input int s);
        return ((w % s) == 0) ? s : (w % s);
    endfunction

endpackage

// File: rtl/qlf_k6n10_seg_adder.sv
// One carry-chain segment: sum = a + b + cin, with
// carry out and an all-zero flag on the sum.
module qlf_k6n10_seg_adder #(
    parameter int SEG = 20
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_zero
);

    assign {o_cout, o_sum} = {1'b0, i_a}
                           + {1'b0, i_b}
                           + {{SEG{1'b0}}, i_cin};

    assign o_zero = ~|o_sum;

endmodule

// File: rtl/qlf_k6n10_seg_sub.sv
// Multi-cycle subtractor: a - b computed one SEG-bit
// segment per cycle through a single reused adder.
module qlf_k6n10_seg_sub
    import qlf_k6n10_arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             borrow,
    output logic             eq,
    output logic             lt
);

    localparam int NSEG  = calc_nseg(WIDTH, SEG);
    localparam int LASTW = calc_lastw(WIDTH, SEG);
    localparam int PW    = NSEG * SEG;
    localparam int IW    = $clog2(NSEG + 1);

    seg_state_t r_state;
    seg_state_t w_next;

    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_nb;
    logic             r_signed;
    logic             r_sa;
    logic             r_sb;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_y;
    logic             r_borrow;
    logic             r_eq;
    logic             r_lt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [SEG-1:0]   w_sum;
    logic             w_cout;
    logic             w_zero;
    logic             w_ovf;

    qlf_k6n10_seg_adder #(
        .SEG(SEG)
    ) u_add (
        .i_a   (r_a[SEG-1:0]),
        .i_b   (r_nb[SEG-1:0]),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout),
        .o_zero(w_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        w_run     = 1'b0;
        w_last    = (r_idx == IW'(NSEG - 1));
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Signed overflow of the final result, judged on the captured sign bits.
    assign w_ovf = (r_sa != r_sb) && (w_sum[LASTW-1] != r_sa);

    // Operands are padded to whole segments: a with ones, ~b with zeros.
    // The pad then passes the tail carry through unchanged and reads as
    // zero exactly when the real tail bits are zero with carry set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_nb     <= '0;
            r_signed <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_carry  <= 1'b1;
            r_idx    <= '0;
            r_y      <= '0;
            r_borrow <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
        end else if (w_accept) begin
            r_a      <= ~PW'(~a);
            r_nb     <= PW'(~b);
            r_signed <= is_signed;
            r_sa     <= a[WIDTH-1];
            r_sb     <= b[WIDTH-1];
            r_carry  <= 1'b1;
            r_idx    <= '0;
            r_eq     <= 1'b1;
        end else if (w_run) begin
            r_a     <= r_a >> SEG;
            r_nb    <= r_nb >> SEG;
            r_carry <= w_cout;
            r_eq    <= r_eq & w_zero;
            if (w_last) begin
                r_y      <= WIDTH'({w_sum, r_y} >> LASTW);
                r_borrow <= ~w_cout;
                r_lt     <= r_signed ? (w_sum[LASTW-1] ^ w_ovf)
                                     : ~w_cout;
                r_idx    <= '0;
            end else begin
                r_y   <= WIDTH'({w_sum, r_y} >> SEG);
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign y      = r_y;
    assign borrow = r_borrow;
    assign eq     = r_eq;
    assign lt     = r_lt;

endmodule

// File: tb/tb_qlf_k6n10_seg_sub.sv
// Scoreboard bench for qlf_k6n10_seg_sub at WIDTH 64, 40 and 41.
// Issuers queue hand-computed results; monitors pop on handshake.
module tb_qlf_k6n10_seg_sub;

    typedef struct {
        logic [63:0] y;
        logic        borrow;
        logic        eq;
        logic        lt;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        iv64 = 0, ir64, s64 = 0, ov64, or64 = 1;
    logic        bw64, eq64, lt64;
    logic [63:0] a64 = '0, b64 = '0, y64;
    logic        iv40 = 0, ir40, s40 = 0, ov40, or40 = 1;
    logic        bw40, eq40, lt40;
    logic [39:0] a40 = '0, b40 = '0, y40;
    logic        iv41 = 0, ir41, s41 = 0, ov41, or41 = 1;
    logic        bw41, eq41, lt41;
    logic [40:0] a41 = '0, b41 = '0, y41;

    qlf_k6n10_seg_sub #(.WIDTH(64), .SEG(20)) u64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .is_signed(s64),
        .out_valid(ov64), .out_ready(or64),
        .y(y64), .borrow(bw64), .eq(eq64), .lt(lt64)
    );

    qlf_k6n10_seg_sub #(.WIDTH(40), .SEG(20)) u40 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv40), .in_ready(ir40),
        .a(a40), .b(b40), .is_signed(s40),
        .out_valid(ov40), .out_ready(or40),
        .y(y40), .borrow(bw40), .eq(eq40), .lt(lt40)
    );

    qlf_k6n10_seg_sub #(.WIDTH(41), .SEG(20)) u41 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv41), .in_ready(ir41),
        .a(a41), .b(b41), .is_signed(s41),
        .out_valid(ov41), .out_ready(or41),
        .y(y41), .borrow(bw41), .eq(eq41), .lt(lt41)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string id, input exp_t e,
                       input logic [63:0] yv, input logic bw,
                       input logic eqv, input logic ltv, input int tv);
        chk({id, "_y"}, yv, e.y);
        chk({id, "_borrow"}, 64'(bw), 64'(e.borrow));
        chk({id, "_eq"}, 64'(eqv), 64'(e.eq));
        chk({id, "_lt"}, 64'(ltv), 64'(e.lt));
        chk({id, "_latency"}, 64'(tv - e.acc + 1), 64'(e.lat));
    endtask

    function automatic logic rdy(input int id);
        case (id)
            0:       return ir64;
            1:       return ir40;
            default: return ir41;
        endcase
    endfunction

    task automatic drive(input int id, input logic v,
                         input logic [63:0] ai, input logic [63:0] bi,
                         input logic s);
        case (id)
            0: begin iv64 = v; a64 = ai; b64 = bi; s64 = s; end
            1: begin iv40 = v; a40 = ai[39:0]; b40 = bi[39:0]; s40 = s; end
            default: begin
                iv41 = v; a41 = ai[40:0]; b41 = bi[40:0]; s41 = s;
            end
        endcase
    endtask

    task automatic issue(input int id, input logic [63:0] ai,
                         input logic [63:0] bi, input logic s,
                         input logic [63:0] ey, input logic eb,
                         input logic ee, input logic el);
        int   n = 0;
        exp_t e;
        while (!rdy(id) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!rdy(id)) begin
            chk("issue_ready_timeout", 64'(rdy(id)), 64'd1);
            return;
        end
        drive(id, 1'b1, ai, bi, s);
        @(posedge clk); #1;
        e.y = ey; e.borrow = eb; e.eq = ee; e.lt = el;
        e.acc = cyc;
        e.lat = (id == 0) ? 5 : (id == 1) ? 3 : 4;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        // Scramble operands while running; the result must not move.
        drive(id, 1'b0, ~ai, ~bi, ~s);
    endtask

    int  tv64, tv40, tv41;
    logic pv64 = 0, pv40 = 0, pv41 = 0;

    always @(negedge clk) begin : mon64
        exp_t e;
        if (ov64 && !pv64) tv64 = cyc;
        pv64 = ov64;
        if (ov64 && or64) begin
            if (q0.size() == 0) chk("u64_unexpected_valid", 64'd1, 64'd0);
            else begin
                e = q0.pop_front();
                cmp("u64", e, y64, bw64, eq64, lt64, tv64);
            end
        end
    end

    always @(negedge clk) begin : mon40
        exp_t e;
        if (ov40 && !pv40) tv40 = cyc;
        pv40 = ov40;
        if (ov40 && or40) begin
            if (q1.size() == 0) chk("u40_unexpected_valid", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                cmp("u40", e, 64'(y40), bw40, eq40, lt40, tv40);
            end
        end
    end

    always @(negedge clk) begin : mon41
        exp_t e;
        if (ov41 && !pv41) tv41 = cyc;
        pv41 = ov41;
        if (ov41 && or41) begin
            if (q2.size() == 0) chk("u41_unexpected_valid", 64'd1, 64'd0);
            else begin
                e = q2.pop_front();
                cmp("u41", e, 64'(y41), bw41, eq41, lt41, tv41);
            end
        end
    end

    initial begin : stim
        logic [63:0] r;
        int          n;
        #1;
        chk("reset_y", y64, 64'd0);
        chk("reset_ctl", 64'({ov64, ir64, bw64, eq64, lt64}), 64'b01000);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        issue(0, 64'd100, 64'd58, 0, 64'd42, 0, 0, 0);
        issue(0, 64'd0, 64'd1, 0, '1, 1, 0, 1);
        issue(0, 64'd0, 64'd1, 1, '1, 1, 0, 1);
        issue(0, 64'h8000_0000_0000_0000, 64'd1, 1,
              64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1);
        issue(0, 64'h8000_0000_0000_0000, 64'd1, 0,
              64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0);
        issue(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1,
              64'd0, 0, 1, 0);
        issue(0, '1, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1);
        issue(0, 64'd5, 64'h7FFF_FFFF_FFFF_FFFF, 1,
              64'h8000_0000_0000_0006, 1, 0, 1);
        issue(0, 64'h7FFF_FFFF_FFFF_FFFF, '1, 1,
              64'h8000_0000_0000_0000, 1, 0, 0);
        issue(0, 64'h0000_0000_0010_0000, 64'd1, 0,
              64'h0000_0000_000F_FFFF, 0, 0, 0);

        r = {$urandom, $urandom};
        issue(1, r, r, 0, 64'd0, 0, 1, 0);
        issue(1, 64'd0, 64'd1, 0, 64'hFF_FFFF_FFFF, 1, 0, 1);
        r = {$urandom, $urandom};
        issue(2, r, r, 1, 64'd0, 0, 1, 0);
        issue(2, 64'd0, 64'd1, 0, 64'h1FF_FFFF_FFFF, 1, 0, 1);
        issue(2, 64'h100_0000_0000, 64'd0, 1,
              64'h100_0000_0000, 0, 0, 1);

        // Consumer stall: outputs must hold while out_ready is low.
        or64 = 1'b0;
        issue(0, 64'd100, 64'd58, 0, 64'd42, 0, 0, 0);
        n = 0;
        while (!ov64 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("stall_valid", 64'(ov64), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_y", y64, 64'd42);
            chk("stall_ctl", 64'({ov64, ir64, bw64, eq64, lt64}),
                64'b10000);
        end
        or64 = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", 64'({ir64, ov64}), 64'b10);

        // Reset in the second RUN cycle abandons the operation.
        n = 0;
        while (!ir64 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        drive(0, 1'b1, 64'd5, 64'd3, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 64'd5, 64'd3, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_y", y64, 64'd0);
        chk("midrun_reset_ctl", 64'({ov64, ir64, bw64, eq64, lt64}),
            64'b01000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        issue(0, 64'd5, 64'd3, 0, 64'd2, 0, 0, 0);

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qlf_k6n10_seg_sub.md
QLF_K6N10_SEG_SUB -- requirements
Module: qlf_k6n10_seg_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal range 2..256).
REQ-002 SHALL have parameter SEG, default 20, bits per segment, matching one k6n10 carry-chain length.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands presented.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port a, input, WIDTH, minuend.
REQ-008 SHALL have port b, input, WIDTH, subtrahend.
REQ-009 SHALL have port is_signed, input, 1, operands are two's complement (sampled with a, b).
REQ-010 SHALL have port out_valid, output, 1, result held.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port y, output, WIDTH, a - b mod 2^WIDTH.
REQ-013 SHALL have port borrow, output, 1, unsigned borrow out (a < b unsigned).
REQ-014 SHALL have port eq, output, 1, a == b.
REQ-015 SHALL have port lt, output, 1, a < b, signed or unsigned per is_signed.

Function
REQ-016 SHALL compute a - b as a + ~b + 1, one SEG-bit segment per cycle, LSB segment first, carry registered between segments.
REQ-017 SHALL use NSEG = ceil(WIDTH/SEG) segments; the last segment SHALL process only the WIDTH mod SEG remaining bits when nonzero, with upper segment bits ignored.
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, SHALL capture a, b, is_signed, set carry=1, segment index=0, go to RUN.
REQ-020 RUN: in_ready=0; each cycle SHALL write one segment of y, update carry, AND segment-zero flag into eq; after segment NSEG-1, go to DONE.
REQ-021 DONE: out_valid=1, y/borrow/eq/lt stable; on out_ready, go to IDLE.
REQ-022 Latency from accepting handshake cycle to out_valid high SHALL be exactly NSEG+1 cycles.
REQ-023 borrow SHALL equal the inverse of the final carry-out.
REQ-024 lt SHALL equal borrow when is_signed=0, and (sign of y) XOR (signed overflow) when is_signed=1, overflow = a[WIDTH-1]!=b[WIDTH-1] && y[WIDTH-1]!=a[WIDTH-1].
REQ-025 in_ready SHALL be combinationally independent of out_ready; no new operand is accepted in the DONE->IDLE handoff cycle (throughput one op per NSEG+2 cycles).
REQ-026 Operand changes on a/b while not in IDLE SHALL have no effect on the running result.
REQ-027 out_valid held with out_ready=0 SHALL keep all outputs unchanged indefinitely.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE, in_ready=1, out_valid=0, y=0, borrow=0, eq=0, lt=0, carry=1, segment index=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abandon the operation without any out_valid pulse.
REQ-030 After reset_n deasserts, the first rising edge SHALL be able to accept an operand.

Structure
REQ-031 State encoding enum and NSEG/last-segment-width derivation SHALL reside in shared package qlf_k6n10_arith_pkg.
REQ-032 One sub-module, qlf_k6n10_seg_adder (SEG-bit combinational a+b+cin -> sum, cout, zero), SHALL be instantiated once and reused each cycle.
REQ-033 No multipliers or WIDTH-wide adders SHALL be inferred outside the segment adder.

Verification
REQ-034 WIDTH=64, a=100, b=58, is_signed=0 -> after 5 cycles out_valid, y=42, borrow=0, eq=0, lt=0.
REQ-035 WIDTH=64, a=0, b=1, is_signed=0 -> y=all-ones, borrow=1, lt=1; same with is_signed=1 -> lt=1.
REQ-036 WIDTH=64, a=0x8000_0000_0000_0000, b=1, is_signed=1 -> y=0x7FFF_FFFF_FFFF_FFFF, lt=1, borrow=0.
REQ-037 WIDTH=40 (exact 2 segments) and WIDTH=41 (3 segments, 1-bit tail), a=b=random -> y=0, eq=1, latency 3 and 4 cycles respectively.
REQ-038 out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-039 reset_n pulsed low in cycle 2 of RUN -> all outputs zero, out_valid never asserted, next operand computes correctly.
